pc_fetch_unit: RTL and testbench

Instruction-fetch stage for the simpleCPU pipeline: holds the program counter, drives the instruction-memory address, and loads the IF/ID pipeline register. It consumes the next-PC select (Pcsrc) and condition-dependency flag (Condep) from the PC control logic. It applies sequential redirects (branch from EX, jump from ID), stalls, and bubble insertion. A redirect-statistics counter and a sticky protocol-error flag are included for verification and debug.

---
 rtl/pc_fetch_unit_if.sv | 27 ++
 rtl/pc_fetch_unit.sv | 80 ++++++++
 tb/tb_pc_fetch_unit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bundle: PC control inputs, instruction-memory port, IF/ID register
// outputs and debug status. The slave modport is the fetch unit.
interface pc_fetch_unit_if;
    logic [1:0]  Pcsrc;
    logic        Condep;
    logic [31:0] BrTarget;
    logic [25:0] JTarget;
    logic        Stall;
    logic [31:0] IMemData;
    logic [31:0] IMemAddr;
    logic [31:0] IfId_Instr;
    logic [31:0] IfId_Pc4;
    logic        IfId_Valid;
    logic        IdEx_Flush;
    logic [15:0] FlushCnt;
    logic        Err;

    modport master (
        output Pcsrc, Condep, BrTarget, JTarget, Stall, IMemData,
        input  IMemAddr, IfId_Instr, IfId_Pc4, IfId_Valid, IdEx_Flush, FlushCnt, Err
    );

    modport slave (
        input  Pcsrc, Condep, BrTarget, JTarget, Stall, IMemData,
        output IMemAddr, IfId_Instr, IfId_Pc4, IfId_Valid, IdEx_Flush, FlushCnt, Err
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: program counter, instruction-memory address and IF/ID register,
// with branch/jump redirects, load-use stalls, bubble insertion, redirect count and sticky error.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic            clk,
    input logic            rst,
    pc_fetch_unit_if.slave fetch
);
    localparam logic [1:0] SEL_RSVD   = 2'b01;
    localparam logic [1:0] SEL_BRANCH = 2'b10;
    localparam logic [1:0] SEL_JUMP   = 2'b11;

    logic [31:0] pc_p0;
    logic [31:0] instr_p1;
    logic [31:0] pc4_p1;
    logic        vld_p1;
    logic [15:0] flush_cnt;
    logic        err;

    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic        take_branch;
    logic        take_jump;
    logic        redirect;
    logic        proto_err;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    // A jump held in ID by a stall waits; a branch wins over the stall because
    // the stalled ID instruction is on the wrong path anyway.
    always_comb begin
        pc_plus4    = pc_p0 + 32'd4;
        jump_target = {pc4_p1[31:28], fetch.JTarget, 2'b00};
        take_branch = (fetch.Pcsrc == SEL_BRANCH);
        take_jump   = (fetch.Pcsrc == SEL_JUMP) && !fetch.Stall;
        redirect    = take_branch || take_jump;
        proto_err   = (fetch.Pcsrc == SEL_RSVD)
                    || (take_branch && fetch.Condep)
                    || (!fetch.Condep && !take_branch);
    end

    // Stage boundary: PC (p0) feeds IMemAddr; IF/ID (p1) captures fetched instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_p0     <= RESET_PC;
            instr_p1  <= '0;
            pc4_p1    <= '0;
            vld_p1    <= 1'b0;
            flush_cnt <= '0;
            err       <= 1'b0;
        end else begin
            if (proto_err) begin
                err <= 1'b1;
            end
            if (redirect) begin
                pc_p0     <= take_branch ? fetch.BrTarget : jump_target;
                instr_p1  <= '0;
                pc4_p1    <= '0;
                vld_p1    <= 1'b0;
                flush_cnt <= sat_inc(flush_cnt);
            end else if (!fetch.Stall) begin
                pc_p0    <= pc_plus4;
                instr_p1 <= fetch.IMemData;
                pc4_p1   <= pc_plus4;
                vld_p1   <= 1'b1;
            end
        end
    end

    assign fetch.IMemAddr   = pc_p0;
    assign fetch.IfId_Instr = instr_p1;
    assign fetch.IfId_Pc4   = pc4_p1;
    assign fetch.IfId_Valid = vld_p1;
    assign fetch.IdEx_Flush = !fetch.Condep && !rst;
    assign fetch.FlushCnt   = flush_cnt;
    assign fetch.Err        = err;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table, hand-written corner sequences and
// randomized traffic compared against an abstract reference model of the fetch stage.
module tb_pc_fetch_unit;
    logic clk;
    logic rst;
    pc_fetch_unit_if fif();

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst   (rst),
        .fetch (fif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pc4;
    bit          m_valid, m_err;
    int          m_cnt;

    typedef struct {
        logic [1:0]  pcsrc;
        logic        condep;
        logic [31:0] brt;
        logic [25:0] jt;
        logic        stall;
        logic [31:0] imem;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
        logic [15:0] e_cnt;
        logic        e_err;
    } vec_t;

    vec_t tbl [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] add4(input logic [31:0] a);
        longint s;
        s = (longint'(a) + 4) % 64'h1_0000_0000;
        return s[31:0];
    endfunction

    task automatic model_step(input logic r, input logic [1:0] ps, input logic cd,
                              input logic [31:0] bt, input logic [25:0] jt,
                              input logic st, input logic [31:0] im);
        logic [31:0] nxt;
        if (r) begin
            m_pc = 32'h0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0; m_err = 0;
            return;
        end
        if (ps == 2'b01 || (ps == 2'b10 && cd) || (!cd && ps != 2'b10)) m_err = 1;
        if (ps == 2'b10 || (ps == 2'b11 && !st)) begin
            m_pc    = (ps == 2'b10) ? bt : {m_pc4[31:28], jt, 2'b00};
            m_instr = 0; m_pc4 = 0; m_valid = 0;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end else if (!st) begin
            nxt     = add4(m_pc);
            m_instr = im; m_pc4 = nxt; m_valid = 1; m_pc = nxt;
        end
    endtask

    task automatic step(input logic r, input logic [1:0] ps, input logic cd,
                        input logic [31:0] bt, input logic [25:0] jt,
                        input logic st, input logic [31:0] im, input bit chk_flush);
        rst = r;
        fif.Pcsrc = ps; fif.Condep = cd; fif.BrTarget = bt; fif.JTarget = jt;
        fif.Stall = st; fif.IMemData = im;
        #1;
        if (chk_flush) check("idex_flush", 32'(fif.IdEx_Flush), 32'(!cd && !r));
        model_step(r, ps, cd, bt, jt, st, im);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string pfx);
        check({pfx, "_addr"},  fif.IMemAddr,          m_pc);
        check({pfx, "_instr"}, fif.IfId_Instr,        m_instr);
        check({pfx, "_pc4"},   fif.IfId_Pc4,          m_pc4);
        check({pfx, "_valid"}, 32'(fif.IfId_Valid),   32'(m_valid));
        check({pfx, "_cnt"},   32'(fif.FlushCnt),     32'(m_cnt));
        check({pfx, "_err"},   32'(fif.Err),          32'(m_err));
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_addr"},  fif.IMemAddr,        32'h0);
        check({pfx, "_instr"}, fif.IfId_Instr,      32'h0);
        check({pfx, "_pc4"},   fif.IfId_Pc4,        32'h0);
        check({pfx, "_valid"}, 32'(fif.IfId_Valid), 32'h0);
        check({pfx, "_cnt"},   32'(fif.FlushCnt),   32'h0);
        check({pfx, "_err"},   32'(fif.Err),        32'h0);
    endtask

    initial begin
        logic [1:0] ps;
        logic       cd, st, r;
        int         k;

        tbl[0]  = '{2'b00, 1'b1, 32'h0, 26'h0, 1'b0, 32'hA0A0_0000, 32'h0000_0004, 32'hA0A0_0000, 32'h0000_0004, 1'b1, 16'd0, 1'b0};
        tbl[1]  = '{2'b00, 1'b1, 32'h0, 26'h0, 1'b0, 32'hA1A1_0001, 32'h0000_0008, 32'hA1A1_0001, 32'h0000_0008, 1'b1, 16'd0, 1'b0};
        tbl[2]  = '{2'b00, 1'b1, 32'h0, 26'h0, 1'b0, 32'hA2A2_0002, 32'h0000_000C, 32'hA2A2_0002, 32'h0000_000C, 1'b1, 16'd0, 1'b0};
        tbl[3]  = '{2'b00, 1'b1, 32'h0, 26'h0, 1'b0, 32'hA3A3_0003, 32'h0000_0010, 32'hA3A3_0003, 32'h0000_0010, 1'b1, 16'd0, 1'b0};
        tbl[4]  = '{2'b10, 1'b0, 32'h40, 26'h0, 1'b1, 32'hDEAD_BEEF, 32'h0000_0040, 32'h0, 32'h0, 1'b0, 16'd1, 1'b0};
        tbl[5]  = '{2'b00, 1'b1, 32'h0, 26'h0, 1'b0, 32'hB0B0_0000, 32'h0000_0044, 32'hB0B0_0000, 32'h0000_0044, 1'b1, 16'd1, 1'b0};
        tbl[6]  = '{2'b10, 1'b0, 32'h1000_0004, 26'h0, 1'b0, 32'h1111_1111, 32'h1000_0004, 32'h0, 32'h0, 1'b0, 16'd2, 1'b0};
        tbl[7]  = '{2'b00, 1'b1, 32'h0, 26'h0, 1'b0, 32'hC0C0_0000, 32'h1000_0008, 32'hC0C0_0000, 32'h1000_0008, 1'b1, 16'd2, 1'b0};
        tbl[8]  = '{2'b11, 1'b1, 32'h0, 26'h10, 1'b0, 32'h2222_2222, 32'h1000_0040, 32'h0, 32'h0, 1'b0, 16'd3, 1'b0};
        tbl[9]  = '{2'b10, 1'b0, 32'h1000_0004, 26'h0, 1'b0, 32'h3333_3333, 32'h1000_0004, 32'h0, 32'h0, 1'b0, 16'd4, 1'b0};
        tbl[10] = '{2'b00, 1'b1, 32'h0, 26'h0, 1'b0, 32'hC1C1_0001, 32'h1000_0008, 32'hC1C1_0001, 32'h1000_0008, 1'b1, 16'd4, 1'b0};
        tbl[11] = '{2'b11, 1'b1, 32'h0, 26'h10, 1'b1, 32'h4444_4444, 32'h1000_0008, 32'hC1C1_0001, 32'h1000_0008, 1'b1, 16'd4, 1'b0};
        tbl[12] = '{2'b11, 1'b1, 32'h0, 26'h10, 1'b1, 32'h5555_5555, 32'h1000_0008, 32'hC1C1_0001, 32'h1000_0008, 1'b1, 16'd4, 1'b0};
        tbl[13] = '{2'b11, 1'b1, 32'h0, 26'h10, 1'b0, 32'h6666_6666, 32'h1000_0040, 32'h0, 32'h0, 1'b0, 16'd5, 1'b0};
        tbl[14] = '{2'b01, 1'b1, 32'h0, 26'h0, 1'b0, 32'hD0D0_0000, 32'h1000_0044, 32'hD0D0_0000, 32'h1000_0044, 1'b1, 16'd5, 1'b1};
        tbl[15] = '{2'b00, 1'b1, 32'h0, 26'h0, 1'b0, 32'hD1D1_0001, 32'h1000_0048, 32'hD1D1_0001, 32'h1000_0048, 1'b1, 16'd5, 1'b1};
        tbl[16] = '{2'b10, 1'b0, 32'hFFFF_FFFC, 26'h0, 1'b0, 32'h7777_7777, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 16'd6, 1'b1};
        tbl[17] = '{2'b00, 1'b1, 32'h0, 26'h0, 1'b0, 32'hE0E0_0000, 32'h0000_0000, 32'hE0E0_0000, 32'h0000_0000, 1'b1, 16'd6, 1'b1};

        m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0; m_err = 0;

        // Reset held with a Condep=0 input: flush must stay low while in reset
        step(1'b1, 2'b00, 1'b0, 32'h0, 26'h0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 2'b10, 1'b0, 32'h80, 26'h0, 1'b0, 32'h0, 1'b1);
        check_reset_state("reset");

        for (int i = 0; i < 18; i++) begin
            step(1'b0, tbl[i].pcsrc, tbl[i].condep, tbl[i].brt, tbl[i].jt,
                 tbl[i].stall, tbl[i].imem, 1'b1);
            check($sformatf("vec%0d_addr", i),  fif.IMemAddr,          tbl[i].e_addr);
            check($sformatf("vec%0d_instr", i), fif.IfId_Instr,        tbl[i].e_instr);
            check($sformatf("vec%0d_pc4", i),   fif.IfId_Pc4,          tbl[i].e_pc4);
            check($sformatf("vec%0d_valid", i), 32'(fif.IfId_Valid),   32'(tbl[i].e_valid));
            check($sformatf("vec%0d_cnt", i),   32'(fif.FlushCnt),     32'(tbl[i].e_cnt));
            check($sformatf("vec%0d_err", i),   32'(fif.Err),          32'(tbl[i].e_err));
        end

        // Err stays set until reset, then clears
        step(1'b0, 2'b00, 1'b1, 32'h0, 26'h0, 1'b0, 32'h0, 1'b1);
        check("err_sticky", 32'(fif.Err), 32'h1);
        step(1'b1, 2'b00, 1'b1, 32'h0, 26'h0, 1'b0, 32'h0, 1'b1);
        check_reset_state("err_rst");

        // Condep=0 without a branch is a protocol error; the PC still advances
        step(1'b0, 2'b00, 1'b0, 32'h0, 26'h0, 1'b0, 32'h1234_5678, 1'b1);
        check("condep_err", 32'(fif.Err), 32'h1);
        check("condep_addr", fif.IMemAddr, 32'h4);
        check("condep_instr", fif.IfId_Instr, 32'h1234_5678);
        step(1'b1, 2'b00, 1'b1, 32'h0, 26'h0, 1'b0, 32'h0, 1'b1);

        // Saturation of the redirect counter
        for (int i = 0; i < 65535; i++)
            step(1'b0, 2'b10, 1'b0, 32'(i) << 2, 26'h0, 1'b0, 32'h0, 1'b0);
        check("sat_reach", 32'(fif.FlushCnt), 32'h0000_FFFF);
        for (int i = 0; i < 2; i++)
            step(1'b0, 2'b10, 1'b0, 32'h100, 26'h0, 1'b0, 32'h0, 1'b0);
        check("sat_hold", 32'(fif.FlushCnt), 32'h0000_FFFF);
        check("sat_addr", fif.IMemAddr, 32'h100);
        step(1'b1, 2'b10, 1'b0, 32'h200, 26'h0, 1'b1, 32'h0, 1'b1);
        check_reset_state("sat_rst");
        step(1'b0, 2'b10, 1'b0, 32'h300, 26'h0, 1'b0, 32'h0, 1'b1);
        check("post_rst_cnt", 32'(fif.FlushCnt), 32'h1);
        check_model("post_rst");

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 49) == 0);
            k  = $urandom_range(0, 19);
            ps = (k < 11) ? 2'b00 : (k < 15) ? 2'b10 : (k < 19) ? 2'b11 : 2'b01;
            cd = (ps != 2'b10);
            if ($urandom_range(0, 15) == 0) cd = ~cd;
            st = ($urandom_range(0, 3) == 0);
            step(r, ps, cd, $urandom, 26'($urandom), st, $urandom, 1'b1);
            check_model($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
